// File: rtl/morse_letter_ctrl.sv
// Morse key-entry sequencer: synchronise/debounce keys, assemble up to 4 symbols per letter.
// Build option MORSE_HOLD_DASH_EN: single-key keying on button1, dash/dot chosen by hold time.
module morse_letter_ctrl #(
  parameter int CLK_HZ      = 27000000,
  parameter int TICK_HZ     = 1000,
  parameter int DEBOUNCE_MS = 20,
  parameter int GAP_MS      = 1000,
  parameter int DASH_MS     = 300
) (
  input  logic       CLKin,
  input  logic       rst,
  input  logic       button1,
  input  logic       button2,
  input  logic       clear,
  output logic [3:0] code,
  output logic [2:0] len,
  output logic       valid,
  output logic       busy
);
  localparam int PRESC = CLK_HZ / TICK_HZ;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int TMAX0 = (DEBOUNCE_MS > GAP_MS) ? DEBOUNCE_MS : GAP_MS;
  localparam int TMAX  = (TMAX0 > DASH_MS) ? TMAX0 : DASH_MS;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, EMIT = 2'd2} state_t;

  logic [PW-1:0]       presc_q, presc_d;
  logic                tick_q, tick_d;
  logic [1:0]          sync1_q, sync2_q, raw_s;
  logic [1:0][TW-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]          lvl_q, lvl_d, press_q, press_d;
  state_t              state_q, state_d;
  logic [3:0]          acc_q, acc_d, code_q, code_d;
  logic [2:0]          cnt_q, cnt_d, len_q, len_d;
  logic [TW-1:0]       gap_q, gap_d;
  logic                valid_q, valid_d, busy_q, busy_d;
  logic                sym_evt_s, sym_val_s, quiet_s;

  // Keys are active-low: a 1 in raw_s means the key is held down.
  assign raw_s = ~sync2_q;

  // Timebase prescaler and per-key debounce counters.
  always_comb begin
    if (presc_q == PW'(PRESC - 1)) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q + PW'(1);
      tick_d  = 1'b0;
    end
    db_cnt_d = db_cnt_q;
    lvl_d    = lvl_q;
    for (int k = 0; k < 2; k++) begin
      if (raw_s[k] == lvl_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (tick_q) begin
        if (db_cnt_q[k] == TW'(DEBOUNCE_MS - 1)) begin
          db_cnt_d[k] = '0;
          lvl_d[k]    = raw_s[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + TW'(1);
        end
      end else begin
        db_cnt_d[k] = db_cnt_q[k];
      end
    end
    press_d = lvl_d & ~lvl_q;
  end

`ifdef MORSE_HOLD_DASH_EN
  logic [TW-1:0] hold_q, hold_d;
  logic          rel_q, rel_d;

  // Hold-time measurement on button1; the symbol is taken on debounced release.
  always_comb begin
    rel_d = lvl_q[0] & ~lvl_d[0];
    if (press_q[0]) begin
      hold_d = '0;
    end else if (lvl_q[0] && tick_q && (hold_q != TW'(DASH_MS))) begin
      hold_d = hold_q + TW'(1);
    end else begin
      hold_d = hold_q;
    end
  end

  // Hold counter and release-event registers.
  always_ff @(posedge CLKin or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      rel_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rel_q  <= rel_d;
    end
  end

  assign sym_evt_s = rel_q;
  assign sym_val_s = (hold_q == TW'(DASH_MS));
  assign quiet_s   = ~lvl_q[0];
`else
  // Simultaneous presses resolve to a dot.
  assign sym_evt_s = |press_q;
  assign sym_val_s = ~press_q[0];
  assign quiet_s   = ~(|lvl_q);
`endif

  // Letter assembly FSM next-state and output load.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    code_d  = code_q;
    len_d   = len_q;
    valid_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      acc_d   = 4'b0000;
      cnt_d   = 3'd0;
      gap_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sym_evt_s) begin
            acc_d   = {3'b000, sym_val_s};
            cnt_d   = 3'd1;
            gap_d   = '0;
            state_d = COLLECT;
          end else begin
            state_d = IDLE;
          end
        end
        COLLECT: begin
          if (sym_evt_s) begin
            acc_d[cnt_q[1:0]] = sym_val_s;
            cnt_d = cnt_q + 3'd1;
            gap_d = '0;
            if (cnt_d == 3'd4) begin
              state_d = EMIT;
            end else begin
              state_d = COLLECT;
            end
          end else if (tick_q && quiet_s) begin
            if (gap_q != TW'(GAP_MS)) begin
              gap_d = gap_q + TW'(1);
            end else begin
              gap_d = gap_q;
            end
            if (gap_d == TW'(GAP_MS)) begin
              state_d = EMIT;
            end else begin
              state_d = COLLECT;
            end
          end else begin
            state_d = COLLECT;
          end
        end
        EMIT: begin
          state_d = IDLE;
          acc_d   = 4'b0000;
          cnt_d   = 3'd0;
          gap_d   = '0;
        end
        default: begin
          state_d = IDLE;
          acc_d   = 4'b0000;
          cnt_d   = 3'd0;
          gap_d   = '0;
        end
      endcase
      // Outputs are loaded on the edge that enters EMIT so they line up with valid.
      if ((state_d == EMIT) && (state_q == COLLECT)) begin
        code_d  = acc_d;
        len_d   = cnt_d;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
    busy_d = (state_d != IDLE);
  end

  // All datapath, FSM and output registers.
  always_ff @(posedge CLKin or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      tick_q   <= 1'b0;
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      db_cnt_q <= '0;
      lvl_q    <= 2'b00;
      press_q  <= 2'b00;
      state_q  <= IDLE;
      acc_q    <= 4'b0000;
      cnt_q    <= 3'd0;
      gap_q    <= '0;
      code_q   <= 4'b0000;
      len_q    <= 3'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      sync1_q  <= {button2, button1};
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      lvl_q    <= lvl_d;
      press_q  <= press_d;
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      code_q   <= code_d;
      len_q    <= len_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign code  = code_q;
  assign len   = len_q;
  assign valid = valid_q;
  assign busy  = busy_q;
endmodule
